// File: rtl/friscv_pkg.sv
// Shared FRiscV core types and constants.
// Covers the architectural widths, the memory geometry and the fetch-stage types.
package friscv_pkg;

  localparam int XLEN            = 32;
  localparam int XLEN_BYTES      = XLEN / 8;
  localparam int INSTR_BYTES     = XLEN_BYTES;
  localparam int IMEM_ADDR_WIDTH = 12;
  localparam int DMEM_ADDR_WIDTH = 12;

  // Depths are in words, so byte spaces are divided by the word size.
  localparam int IMEM_DEPTH = (1 << IMEM_ADDR_WIDTH) / XLEN_BYTES;
  localparam int DMEM_DEPTH = (1 << DMEM_ADDR_WIDTH) / XLEN_BYTES;

  localparam logic [XLEN-1:0] EXCEPTION_ADDRESS = 32'h0000_0000;

  typedef enum logic [0:0] {BOOT, RUN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/friscv_fetch_stage_if.sv
// Instruction-memory read port.
// The fetch stage is the master; the synchronous imem is the slave.
interface friscv_fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 12
);
  logic [AW-1:0]   imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (output imem_addr_o, input  imem_rdata_i);
  modport slave  (input  imem_addr_o, output imem_rdata_i);
endinterface

// File: rtl/friscv_next_pc.sv
// Combinational next-PC selection with redirect alignment check.
// Priority: redirect (a misaligned target traps), then stall, then sequential.
module friscv_next_pc #(
  parameter int XLEN = friscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic [XLEN-1:0] npc,
  output logic            misaligned
);
  import friscv_pkg::*;

  assign misaligned = redirect && is_misaligned(redirect_addr);

  always_comb begin
    npc = pc + XLEN'(INSTR_BYTES);
    if (redirect)   npc = misaligned ? XLEN'(EXCEPTION_ADDRESS) : redirect_addr;
    else if (stall) npc = pc;
  end

endmodule

// File: rtl/friscv_fetch_stage.sv
// IF stage: owns the PC, drives the synchronous imem and the IF/ID register.
// pc_q names the word whose data is on imem_rdata_i in the current cycle.
module friscv_fetch_stage #(
  parameter int              XLEN            = friscv_pkg::XLEN,
  parameter int              IMEM_ADDR_WIDTH = friscv_pkg::IMEM_ADDR_WIDTH,
  parameter logic [XLEN-1:0] RESET_ADDR      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_addr_i,
  friscv_fetch_stage_if.master imem,
  output logic [XLEN-1:0]     if_id_instr_o,
  output logic [XLEN-1:0]     if_id_pc_o,
  output logic                if_id_valid_o,
  output logic                fetch_exc_o,
  output logic [XLEN-1:0]     fetch_exc_addr_o
);
  import friscv_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc;
  logic            trap;
  if_id_t          if_id_q;

  // In BOOT the stage always advances; stalls only take effect once running.
  friscv_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc            (pc_q),
    .stall         (stall_i && (state == RUN)),
    .redirect      (redirect_i),
    .redirect_addr (redirect_addr_i),
    .npc           (npc),
    .misaligned    (trap)
  );

  // Upper PC bits are dropped here on purpose; the imem aliases.
  assign imem.imem_addr_o = rst ? RESET_ADDR[IMEM_ADDR_WIDTH-1:0]
                                : npc[IMEM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= BOOT;
      pc_q             <= RESET_ADDR;
      if_id_q          <= '0;
      fetch_exc_o      <= 1'b0;
      fetch_exc_addr_o <= '0;
    end else begin
      state       <= RUN;
      pc_q        <= npc;
      fetch_exc_o <= trap;
      if (trap) fetch_exc_addr_o <= redirect_addr_i;
      // A flush wins over a stall; instr/pc are left as they were.
      if (redirect_i || (state == BOOT)) begin
        if_id_q.valid <= 1'b0;
      end else if (!stall_i) begin
        if_id_q.instr <= imem.imem_rdata_i;
        if_id_q.pc    <= pc_q;
        if_id_q.valid <= 1'b1;
      end
    end
  end

  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_friscv_fetch_stage.sv
// Bench for friscv_fetch_stage: a directed vector table, then random traffic.
// Every cycle is also checked against a word-level model of fetch behaviour.
module tb_friscv_fetch_stage;
  import friscv_pkg::*;

  localparam int AW    = IMEM_ADDR_WIDTH;
  localparam int WORDS = (1 << AW) / 4;

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i;
  logic [31:0] redirect_addr_i;
  logic [31:0] if_id_instr_o, if_id_pc_o, fetch_exc_addr_o;
  logic        if_id_valid_o, fetch_exc_o;
  logic [31:0] mem [WORDS];

  int errors = 0;
  int checks = 0;

  friscv_fetch_stage_if #(.XLEN(XLEN), .AW(AW)) imem ();

  friscv_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_addr_i  (redirect_addr_i),
    .imem             (imem),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_valid_o    (if_id_valid_o),
    .fetch_exc_o      (fetch_exc_o),
    .fetch_exc_addr_o (fetch_exc_addr_o)
  );

  always #5 clk = ~clk;

  // Synchronous imem: one cycle of read latency.
  always @(posedge clk) imem.imem_rdata_i <= mem[imem.imem_addr_o[AW-1:2]];

  typedef struct {
    bit          r, s, d;
    logic [31:0] a;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
    bit          e_x;
    logic [31:0] e_xa;
  } vec_t;

  // Word-level model: what decode should hold, plus the word currently being read.
  logic [31:0] m_pc, m_instr, m_ipc, m_xa;
  bit          m_boot, m_valid, m_x;

  function automatic vec_t mk(bit r, s, d, logic [31:0] a, logic [31:0] ea, bit ev,
                              logic [31:0] ep, bit ex, logic [31:0] exa);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.a = a;
    v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_x = ex; v.e_xa = exa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_boot = 1; m_valid = 0; m_instr = 0; m_ipc = 0; m_x = 0; m_xa = 0;
  endtask

  task automatic step(input vec_t v, input bit tbl);
    logic [31:0] npc;
    bit          mis;
    rst = v.r; stall_i = v.s; redirect_i = v.d; redirect_addr_i = v.a;
    mis = v.d && (v.a % 4 != 0);
    if (v.r)                     npc = 32'h0;
    else if (v.d)                npc = mis ? EXCEPTION_ADDRESS : v.a;
    else if (v.s && !m_boot)     npc = m_pc;
    else                         npc = m_pc + 32'd4;
    #1;
    chk("m_imem_addr", 32'(imem.imem_addr_o), npc % (1 << AW));
    chk("m_valid",     32'(if_id_valid_o),    32'(m_valid));
    chk("m_pc",        if_id_pc_o,            m_ipc);
    chk("m_instr",     if_id_instr_o,         m_instr);
    chk("m_exc",       32'(fetch_exc_o),      32'(m_x));
    chk("m_exc_addr",  fetch_exc_addr_o,      m_xa);
    if (tbl) begin
      chk("t_imem_addr", 32'(imem.imem_addr_o), v.e_addr);
      chk("t_valid",     32'(if_id_valid_o),    32'(v.e_v));
      chk("t_pc",        if_id_pc_o,            v.e_pc);
      chk("t_exc",       32'(fetch_exc_o),      32'(v.e_x));
      chk("t_exc_addr",  fetch_exc_addr_o,      v.e_xa);
    end
    @(posedge clk);
    if (v.r) model_reset();
    else begin
      m_x = mis;
      if (mis) m_xa = v.a;
      if (m_boot || v.d) m_valid = 0;
      else if (!v.s) begin
        m_instr = mem[m_pc[AW-1:2]];
        m_ipc   = m_pc;
        m_valid = 1;
      end
      m_pc   = npc;
      m_boot = 0;
    end
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    //            r s d addr          imem   v pc            x exc_addr
    tbl.push_back(mk(1,0,0,32'h0,       32'h000,0,32'h0,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h004,0,32'h0,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h008,0,32'h0,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h00C,1,32'h4,       0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,       32'h00C,1,32'h8,       0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,       32'h00C,1,32'h8,       0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,       32'h00C,1,32'h8,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h010,1,32'h8,       0,32'h0));
    tbl.push_back(mk(0,0,1,32'h40,      32'h040,1,32'hC,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h044,0,32'hC,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h048,1,32'h40,      0,32'h0));
    tbl.push_back(mk(0,1,1,32'h80,      32'h080,1,32'h44,      0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h084,0,32'h44,      0,32'h0));
    tbl.push_back(mk(0,0,1,32'h42,      32'h000,1,32'h80,      0,32'h0));
    tbl.push_back(mk(0,1,0,32'h0,       32'h000,0,32'h80,      1,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h004,0,32'h80,      0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h008,1,32'h0,       0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h00C,1,32'h4,       0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h010,1,32'h8,       0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h014,1,32'hC,       0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h018,1,32'h10,      0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h01C,1,32'h14,      0,32'h42));
    tbl.push_back(mk(0,0,0,32'h0,       32'h020,1,32'h18,      0,32'h42));
    tbl.push_back(mk(1,0,0,32'h0,       32'h000,1,32'h1C,      0,32'h42));
    tbl.push_back(mk(0,1,0,32'h0,       32'h004,0,32'h0,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h008,0,32'h0,       0,32'h0));
    tbl.push_back(mk(0,0,1,32'hFFFFFFFC,32'hFFC,1,32'h4,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h000,0,32'h4,       0,32'h0));
    tbl.push_back(mk(0,0,0,32'h0,       32'h004,1,32'hFFFFFFFC,0,32'h0));

    for (int w = 0; w < WORDS; w++) mem[w] = 32'(w * 4);

    rst = 1; stall_i = 0; redirect_i = 0; redirect_addr_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    // Random traffic over random imem contents.
    for (int w = 0; w < WORDS; w++) mem[w] = $urandom;
    v = mk(1,0,0,32'h0,0,0,0,0,0);
    step(v, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      v.r = ($urandom_range(99) == 0);
      v.s = ($urandom_range(3) == 0);
      v.d = ($urandom_range(7) == 0);
      v.a = $urandom;
      if ($urandom_range(3) != 0) v.a[1:0] = 2'b00;
      step(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
